// File: rtl/el2_lsu_trigger_hit_ctl_if.sv
// LSU trigger hit control bus: raw M-stage matches and trigger config in,
// qualified pending hit out toward the TLU.
interface el2_lsu_trigger_hit_ctl_if #(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 4
);
    logic [NUM_TRIG-1:0]       lsu_trigger_match_m;
    logic                      lsu_valid_m;
    logic                      lsu_flush_m;
    logic [NUM_TRIG-1:0]       trig_en;
    logic [NUM_TRIG-1:0]       trig_chain;
    logic [NUM_TRIG*CNT_W-1:0] hit_cnt_cfg;
    logic [NUM_TRIG-1:0]       cfg_wr;
    logic                      dec_tlu_trigger_ack;
    logic                      lsu_trigger_hit_vld;
    logic [NUM_TRIG-1:0]       lsu_trigger_hit_vec;
    logic                      lsu_trigger_hit_ovf;

    modport master (
        output lsu_trigger_match_m, lsu_valid_m, lsu_flush_m,
        output trig_en, trig_chain, hit_cnt_cfg, cfg_wr,
        output dec_tlu_trigger_ack,
        input  lsu_trigger_hit_vld, lsu_trigger_hit_vec,
        input  lsu_trigger_hit_ovf
    );

    modport slave (
        input  lsu_trigger_match_m, lsu_valid_m, lsu_flush_m,
        input  trig_en, trig_chain, hit_cnt_cfg, cfg_wr,
        input  dec_tlu_trigger_ack,
        output lsu_trigger_hit_vld, lsu_trigger_hit_vec,
        output lsu_trigger_hit_ovf
    );
endinterface

// File: rtl/el2_lsu_trigger_hit_ctl.sv
// Turns raw LSU trigger comparator matches into chained, counted trigger
// hits and holds them pending until the TLU acknowledges.
module el2_lsu_trigger_hit_ctl #(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 4
) (
    input logic                   clk,
    input logic                   rst,
    el2_lsu_trigger_hit_ctl_if.slave bus
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t              state_q, state_d;
    logic [NUM_TRIG-1:0] raw, eff, fire;
    logic [NUM_TRIG-1:0] vec_q, vec_d;
    logic                ovf_q, ovf_d;
    logic                any;
    logic [CNT_W-1:0]    cnt_q [NUM_TRIG];
    logic [CNT_W-1:0]    cnt_d [NUM_TRIG];

    // Qualify raw matches, then join chained even/odd pairs.
    always_comb begin
        raw = bus.lsu_trigger_match_m & bus.trig_en &
              {NUM_TRIG{bus.lsu_valid_m & ~bus.lsu_flush_m}};
        eff = raw;
        for (int k = 0; k < NUM_TRIG; k += 2) begin
            if (bus.trig_chain[k]) begin
                eff[k]   = raw[k] & raw[k+1];
                eff[k+1] = raw[k] & raw[k+1];
            end
        end
    end

    // Per-trigger hit counters; a CSR write clears and suppresses the hit.
    always_comb begin
        logic [CNT_W-1:0] cfg;
        logic [CNT_W-1:0] tgt;
        cfg  = '0;
        tgt  = '0;
        fire = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            cnt_d[i] = cnt_q[i];
            cfg      = bus.hit_cnt_cfg[i*CNT_W +: CNT_W];
            tgt      = (cfg <= CNT_W'(1)) ? CNT_W'(1) : cfg;
            if (bus.cfg_wr[i]) begin
                cnt_d[i] = '0;
            end else if (eff[i]) begin
                if (cnt_q[i] + CNT_W'(1) == tgt) begin
                    fire[i]  = 1'b1;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pending-hit handshake: sticky vector and overflow while awaiting ack.
    always_comb begin
        any     = |fire;
        state_d = state_q;
        vec_d   = vec_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = PEND;
                    vec_d   = fire;
                end
            end
            PEND: begin
                if (bus.dec_tlu_trigger_ack) begin
                    ovf_d = 1'b0;
                    if (any) begin
                        vec_d = fire;
                    end else begin
                        state_d = IDLE;
                        vec_d   = '0;
                    end
                end else if (any) begin
                    vec_d = vec_q | fire;
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, hit outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_TRIG; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUM_TRIG; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.lsu_trigger_hit_vld = (state_q == PEND);
    assign bus.lsu_trigger_hit_vec = vec_q;
    assign bus.lsu_trigger_hit_ovf = ovf_q;

endmodule

// File: tb/tb_el2_lsu_trigger_hit_ctl.sv
// Self-checking bench for el2_lsu_trigger_hit_ctl: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_el2_lsu_trigger_hit_ctl;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    int       m_cnt [N];
    int       m_cfg [N];
    bit       m_pend;
    bit [3:0] m_vec;
    bit       m_ovf;

    el2_lsu_trigger_hit_ctl_if #(.NUM_TRIG(N), .CNT_W(W)) bus ();

    el2_lsu_trigger_hit_ctl #(.NUM_TRIG(N), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_pend = 0;
        m_vec  = '0;
        m_ovf  = 0;
    endtask

    task automatic set_cfg(input int i, input int v);
        m_cfg[i] = v;
        bus.hit_cnt_cfg[i*W +: W] = W'(v);
    endtask

    task automatic idle_in();
        bus.lsu_trigger_match_m = '0;
        bus.lsu_valid_m         = 1'b1;
        bus.lsu_flush_m         = 1'b0;
        bus.trig_en             = '1;
        bus.trig_chain          = '0;
        bus.cfg_wr              = '0;
        bus.dec_tlu_trigger_ack = 1'b0;
    endtask

    // Advance the model by one cycle from the current inputs.
    task automatic model_step();
        bit [3:0] hit;
        bit [3:0] fire;
        bit       ok;
        int       need;
        ok = bus.lsu_valid_m && !bus.lsu_flush_m;
        for (int i = 0; i < N; i++)
            hit[i] = ok && bus.lsu_trigger_match_m[i] && bus.trig_en[i];
        for (int k = 0; k < N; k += 2) begin
            if (bus.trig_chain[k]) begin
                hit[k]   = hit[k] && hit[k+1];
                hit[k+1] = hit[k];
            end
        end
        fire = '0;
        for (int i = 0; i < N; i++) begin
            need = (m_cfg[i] < 2) ? 1 : m_cfg[i];
            if (bus.cfg_wr[i]) begin
                m_cnt[i] = 0;
            end else if (hit[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == need) begin
                    fire[i]  = 1;
                    m_cnt[i] = 0;
                end
            end
        end
        if (!m_pend) begin
            if (fire != 0) begin
                m_pend = 1;
                m_vec  = fire;
            end
        end else if (bus.dec_tlu_trigger_ack) begin
            m_ovf = 0;
            m_vec = fire;
            if (fire == 0) m_pend = 0;
        end else if (fire != 0) begin
            m_vec = m_vec | fire;
            m_ovf = 1;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".vld"}, 32'(bus.lsu_trigger_hit_vld), 32'(m_pend));
        chk({tag, ".vec"}, 32'(bus.lsu_trigger_hit_vec), 32'(m_vec));
        chk({tag, ".ovf"}, 32'(bus.lsu_trigger_hit_ovf), 32'(m_ovf));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        cmp_model(tag);
        idle_in();
    endtask

    initial begin
        idle_in();
        for (int i = 0; i < N; i++) set_cfg(i, 1);
        model_reset();
        #1;
        chk("rst.vld", 32'(bus.lsu_trigger_hit_vld), 32'd0);
        chk("rst.vec", 32'(bus.lsu_trigger_hit_vec), 32'd0);
        chk("rst.ovf", 32'(bus.lsu_trigger_hit_ovf), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single hit and ack.
        bus.lsu_trigger_match_m = 4'b0001;
        step("t1.hit");
        chk("t1.vld", 32'(bus.lsu_trigger_hit_vld), 32'd1);
        chk("t1.vec", 32'(bus.lsu_trigger_hit_vec), 32'h1);
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t1.ack");
        chk("t1.clr", 32'(bus.lsu_trigger_hit_vld), 32'd0);

        // Count of three on trigger 1.
        set_cfg(1, 3);
        for (int n = 0; n < 3; n++) begin
            bus.lsu_trigger_match_m = 4'b0010;
            step("t2.cnt");
            chk("t2.vld", 32'(bus.lsu_trigger_hit_vld), 32'(n == 2));
        end
        chk("t2.vec", 32'(bus.lsu_trigger_hit_vec), 32'h2);
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t2.ack");

        // Chain pair 0/1.
        set_cfg(1, 1);
        bus.trig_chain = 4'b0001;
        bus.lsu_trigger_match_m = 4'b0001;
        step("t3.half");
        chk("t3.none", 32'(bus.lsu_trigger_hit_vld), 32'd0);
        bus.trig_chain = 4'b0001;
        bus.lsu_trigger_match_m = 4'b0011;
        step("t3.both");
        chk("t3.vec", 32'(bus.lsu_trigger_hit_vec), 32'h3);
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t3.ack");

        // Flush and disable leave the counter alone.
        set_cfg(2, 2);
        bus.lsu_trigger_match_m = 4'b0100;
        bus.lsu_flush_m = 1'b1;
        step("t4.flush");
        bus.lsu_trigger_match_m = 4'b0100;
        bus.trig_en = 4'b1011;
        step("t4.dis");
        bus.lsu_trigger_match_m = 4'b0100;
        step("t4.one");
        chk("t4.nohit", 32'(bus.lsu_trigger_hit_vld), 32'd0);
        bus.lsu_trigger_match_m = 4'b0100;
        step("t4.two");
        chk("t4.hit", 32'(bus.lsu_trigger_hit_vec), 32'h4);
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t4.ack");

        // Sticky vector, overflow, ack with a fresh hit.
        set_cfg(2, 1);
        bus.lsu_trigger_match_m = 4'b0001;
        step("t5.a");
        bus.lsu_trigger_match_m = 4'b1000;
        step("t5.b");
        chk("t5.vec", 32'(bus.lsu_trigger_hit_vec), 32'h9);
        chk("t5.ovf", 32'(bus.lsu_trigger_hit_ovf), 32'd1);
        bus.lsu_trigger_match_m = 4'b0100;
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t5.c");
        chk("t5.vec2", 32'(bus.lsu_trigger_hit_vec), 32'h4);
        chk("t5.ovf2", 32'(bus.lsu_trigger_hit_ovf), 32'd0);
        bus.dec_tlu_trigger_ack = 1'b1;
        step("t5.ack");

        // CSR write beats a same-cycle match.
        set_cfg(1, 3);
        bus.lsu_trigger_match_m = 4'b0010;
        step("t6.c1");
        bus.lsu_trigger_match_m = 4'b0010;
        step("t6.c2");
        bus.lsu_trigger_match_m = 4'b0010;
        bus.cfg_wr = 4'b0010;
        step("t6.wr");
        chk("t6.nohit", 32'(bus.lsu_trigger_hit_vld), 32'd0);
        bus.lsu_trigger_match_m = 4'b0010;
        step("t6.after");
        chk("t6.cleared", 32'(bus.lsu_trigger_hit_vld), 32'd0);

        // Reset mid-pending.
        set_cfg(1, 1);
        bus.lsu_trigger_match_m = 4'b0011;
        step("t7.pend");
        bus.lsu_trigger_match_m = 4'b1000;
        step("t7.ovf");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t7.vld", 32'(bus.lsu_trigger_hit_vld), 32'd0);
        chk("t7.vec", 32'(bus.lsu_trigger_hit_vec), 32'd0);
        chk("t7.ovf", 32'(bus.lsu_trigger_hit_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bus.lsu_trigger_match_m = 4'($urandom);
            bus.lsu_valid_m         = ($urandom % 8) != 0;
            bus.lsu_flush_m         = ($urandom % 8) == 0;
            bus.trig_en             = 4'($urandom) | 4'($urandom);
            bus.trig_chain          = 4'($urandom);
            bus.dec_tlu_trigger_ack = ($urandom % 3) == 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom % 16 == 0) begin
                    bus.cfg_wr[i] = 1'b1;
                    set_cfg(i, int'($urandom_range(0, 4)));
                end
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
